// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer with PC, 2-entry fetch buffer, redirect and halt
//
// Owns the program counter and addresses the combinational instruction memory.
// Fetched words enter a 2-entry buffer whose head is offered to decode over a
// valid/ready handshake.
//
// Optional feature macro: FETCH_PERF_CNT_EN (adds fetch_cnt, a saturating count
// of accepted handshakes).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   imem_addr       word address to instruction memory ({2'b00, pc[AW-1:2]})
//   imem_data       instruction word for imem_addr, same cycle
//   instr, instr_pc head instruction and its byte PC
//   instr_valid     buffer non-empty
//   instr_ready     decode accepts the head this cycle
//   redirect_valid  taken branch/jump; redirect_pc is the byte target
//   halt_req        level request to stop fetching
//   halted          in HALT with an empty buffer
//   misalign_err    1-cycle pulse after a redirect to a non-word-aligned target
//   fetch_cnt       (FETCH_PERF_CNT_EN only) accepted handshake count

module fetch_ctrl #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_data,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  halt_req,
    output logic                  halted,
    output logic                  misalign_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           fetch_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [1:0]              count_q, count_d;
    logic [DATA_WIDTH-1:0]   buf_data_q [2];
    logic [ADDR_WIDTH-1:0]   buf_pc_q   [2];
    logic                    halted_q;
    logic                    misalign_q;

    logic                    redirect;
    logic                    pop;
    logic                    push;
    logic                    wr_slot;

    assign imem_addr    = {2'b00, pc_q[ADDR_WIDTH-1:2]};
    assign instr        = buf_data_q[0];
    assign instr_pc     = buf_pc_q[0];
    assign instr_valid  = (count_q != 2'd0);
    assign halted       = halted_q;
    assign misalign_err = misalign_q;

    always_comb begin
        // A redirect arriving while still in IDLE is dropped entirely.
        redirect = redirect_valid && (state_q != ST_IDLE);
        // Any redirect_valid blocks the pop, even the ignored IDLE one
        // (the buffer is always empty in IDLE, so this is moot there).
        pop      = instr_valid && instr_ready && !redirect_valid;
        // A full buffer can still accept a word when the head leaves this cycle.
        push     = (state_q == ST_RUN) && !redirect_valid && !halt_req &&
                   ((count_q < 2'd2) || pop);
        // Tail slot after any shift caused by the pop.
        wr_slot  = (count_q == 2'd2) || ((count_q == 2'd1) && !pop);

        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN:  if (!redirect_valid && halt_req) state_d = ST_HALT;
            ST_HALT: if (redirect_valid) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase

        pc_d = pc_q;
        if (redirect) begin
            pc_d = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        end else if (push) begin
            pc_d = pc_q + ADDR_WIDTH'(4);
        end

        count_d = count_q;
        if (redirect) begin
            count_d = 2'd0;
        end else if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            count_q       <= 2'd0;
            buf_data_q[0] <= '0;
            buf_data_q[1] <= '0;
            buf_pc_q[0]   <= '0;
            buf_pc_q[1]   <= '0;
            halted_q      <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            halted_q   <= (state_d == ST_HALT) && (count_d == 2'd0);
            misalign_q <= redirect && (redirect_pc[1:0] != 2'b00);

            // Head always lives in slot 0; popping a full buffer shifts slot 1 up.
            // Popping the last entry leaves slot 0 untouched so instr/instr_pc
            // keep showing the last value while the buffer is empty.
            if (pop && (count_q == 2'd2)) begin
                buf_data_q[0] <= buf_data_q[1];
                buf_pc_q[0]   <= buf_pc_q[1];
            end
            if (push) begin
                if (wr_slot) begin
                    buf_data_q[1] <= imem_data;
                    buf_pc_q[1]   <= pc_q;
                end else begin
                    buf_data_q[0] <= imem_data;
                    buf_pc_q[0]   <= pc_q;
                end
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;

    assign fetch_cnt = fetch_cnt_q;

    // Counts accepted handshakes only; flushed entries were never popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= 32'd0;
        end else if (pop && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl

module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        halted;
    logic        misalign_err;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
`endif

    int n_checks;
    int n_fail;

    fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .halted         (halted),
        .misalign_err   (misalign_err)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt      (fetch_cnt)
`endif
    );

    // Memory word k holds 32'h1000_0000 + k.
    assign imem_data = 32'h1000_0000 + imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt_req       = 1'b0;

        // Reset state
        tick();
        tick();
        check_eq("rst_valid", {31'b0, instr_valid}, 32'd0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_instr_pc", instr_pc, 32'h0);
        check_eq("rst_halted", {31'b0, halted}, 32'd0);
        check_eq("rst_misalign", {31'b0, misalign_err}, 32'd0);
        check_eq("rst_imem_addr", imem_addr, 32'h0);

        // Streaming with ready high: valid two edges after reset release
        rst = 1'b0;
        tick();
        check_eq("idle_valid", {31'b0, instr_valid}, 32'd0);
        tick();
        check_eq("s0_valid", {31'b0, instr_valid}, 32'd1);
        check_eq("s0_pc", instr_pc, 32'h0);
        check_eq("s0_instr", instr, 32'h1000_0000);
        tick();
        check_eq("s1_pc", instr_pc, 32'h4);
        check_eq("s1_instr", instr, 32'h1000_0001);
        tick();
        check_eq("s2_pc", instr_pc, 32'h8);
        check_eq("s2_instr", instr, 32'h1000_0002);
        check_eq("s2_valid", {31'b0, instr_valid}, 32'd1);

        // Backpressure: buffer fills to 2, pc parks at 0x8
        instr_ready = 1'b0;
        do_reset();
        tick();
        tick();
        check_eq("bp_first_pc", instr_pc, 32'h0);
        for (int i = 0; i < 4; i++) tick();
        check_eq("bp_imem_addr", imem_addr, 32'h2);
        check_eq("bp_instr", instr, 32'h1000_0000);
        check_eq("bp_valid", {31'b0, instr_valid}, 32'd1);
        instr_ready = 1'b1;
        tick();
        check_eq("rel0_pc", instr_pc, 32'h4);
        check_eq("rel0_instr", instr, 32'h1000_0001);
        tick();
        check_eq("rel1_pc", instr_pc, 32'h8);
        tick();
        check_eq("rel2_pc", instr_pc, 32'hC);

        // Redirect to 0x40 with a full buffer
        instr_ready = 1'b0;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        check_eq("rd_flush_valid", {31'b0, instr_valid}, 32'd0);
        check_eq("rd_imem_addr", imem_addr, 32'h10);
        check_eq("rd_misalign", {31'b0, misalign_err}, 32'd0);
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        tick();
        check_eq("rd_valid", {31'b0, instr_valid}, 32'd1);
        check_eq("rd_pc", instr_pc, 32'h40);
        check_eq("rd_instr", instr, 32'h1000_0010);

        // Misaligned redirect target 0x42
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        tick();
        check_eq("mis_pulse", {31'b0, misalign_err}, 32'd1);
        redirect_valid = 1'b0;
        tick();
        check_eq("mis_clear", {31'b0, misalign_err}, 32'd0);
        check_eq("mis_pc", instr_pc, 32'h40);

        // Halt with two entries buffered
        instr_ready = 1'b0;
        tick();
        halt_req    = 1'b1;
        instr_ready = 1'b1;
        tick();
        check_eq("h1_pc", instr_pc, 32'h44);
        check_eq("h1_halted", {31'b0, halted}, 32'd0);
        tick();
        check_eq("h2_valid", {31'b0, instr_valid}, 32'd0);
        check_eq("h2_halted", {31'b0, halted}, 32'd1);
        check_eq("h2_imem_addr", imem_addr, 32'h12);
        check_eq("h2_hold_pc", instr_pc, 32'h44);
        tick();
        check_eq("h3_imem_addr", imem_addr, 32'h12);
        check_eq("h3_halted", {31'b0, halted}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        halt_req       = 1'b0;
        tick();
        check_eq("hr_halted", {31'b0, halted}, 32'd0);
        redirect_valid = 1'b0;
        tick();
        check_eq("hr_valid", {31'b0, instr_valid}, 32'd1);
        check_eq("hr_pc", instr_pc, 32'h80);
        check_eq("hr_instr", instr, 32'h1000_0020);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        check_eq("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        check_eq("wrap_instr", instr, 32'h4FFF_FFFF);
        check_eq("wrap_imem_addr", imem_addr, 32'h0);
        tick();
        check_eq("wrap_next_pc", instr_pc, 32'h0);

        // Redirect during IDLE is ignored
        rst = 1'b1;
        tick();
        rst            = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        tick();
        check_eq("idle_rd_misalign", {31'b0, misalign_err}, 32'd0);
        redirect_valid = 1'b0;
        tick();
        check_eq("idle_rd_valid", {31'b0, instr_valid}, 32'd1);
        check_eq("idle_rd_pc", instr_pc, 32'h0);

`ifdef FETCH_PERF_CNT_EN
        do_reset();
        instr_ready = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 10; i++) tick();
        instr_ready = 1'b0;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        check_eq("perf_cnt", fetch_cnt, 32'd10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("perf_rst", fetch_cnt, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
